// File: rtl/dmem_pkg.sv
// Shared types and lane-alignment helpers for the data-memory responder.
package dmem_pkg;

    localparam logic [1:0] SIZE_B  = 2'b00;
    localparam logic [1:0] SIZE_H  = 2'b01;
    localparam logic [1:0] SIZE_W  = 2'b10;
    localparam logic [1:0] SIZE_LD = 2'b11;

    typedef enum logic [2:0] {IDLE, WAIT, ACCESS, RESP, GAP} dmem_state_t;

    // Replicate right-justified store data across every lane it may land in.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            SIZE_B:  store_lanes = {4{wd[7:0]}};
            SIZE_H:  store_lanes = {2{wd[15:0]}};
            default: store_lanes = wd;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SIZE_B:  store_be = 4'b0001 << a;
            SIZE_H:  store_be = 4'b0011 << {a[1], 1'b0};
            SIZE_W:  store_be = 4'b1111;
            default: store_be = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module dmem_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Read-before-write: a write cycle returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Responder side of the core's data-memory port: wait states, lane alignment,
// range/alignment checking and a sticky error flag around a byte-enable RAM.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        memory_en,
    input  logic [1:0]  store_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic        mem_read_data_valid,
    output logic        mem_write_ready,
    output logic        busy,
    output logic        access_err,
    output logic [31:0] err_addr,
    input  logic        err_clear
);

    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

    dmem_state_t   state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   addr_q;
    logic [1:0]    size_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic [AW-1:0] idx_q;
    logic          err_q;
    logic [31:0]   rd_hold_q;
    logic          access_err_q;
    logic [31:0]   err_addr_q;

    logic [31:0]   offset;
    logic          req_err;
    logic          is_load;
    logic          in_resp;
    logic [31:0]   ram_rdata;

    // Unsigned offset makes addresses below the base wrap and fail the range test.
    assign offset  = mem_addr - BASE_ADDR;
    assign req_err = (offset >= SPAN)
                   || (store_size == SIZE_H && mem_addr[0])
                   || (store_size == SIZE_W && mem_addr[1:0] != 2'b00);

    assign is_load = (size_q == SIZE_LD);
    assign in_resp = (state_q == RESP);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (memory_en) begin
                    if (req_err) begin
                        state_d = RESP;
                    end else if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            addr_q       <= 32'd0;
            size_q       <= SIZE_LD;
            wdata_q      <= 32'd0;
            be_q         <= 4'd0;
            idx_q        <= '0;
            err_q        <= 1'b0;
            rd_hold_q    <= 32'd0;
            access_err_q <= 1'b0;
            err_addr_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && memory_en) begin
                addr_q  <= mem_addr;
                size_q  <= store_size;
                wdata_q <= store_lanes(store_size, mem_write_data);
                be_q    <= store_be(store_size, mem_addr[1:0]);
                idx_q   <= offset[AW+1:2];
                err_q   <= req_err;
            end
            if (in_resp && is_load) begin
                rd_hold_q <= mem_read_data;
            end
            // A new error outranks a simultaneous clear.
            if (in_resp && err_q) begin
                access_err_q <= 1'b1;
                err_addr_q   <= addr_q;
            end else if (err_clear) begin
                access_err_q <= 1'b0;
            end
        end
    end

    dmem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk  (CLK),
        .we   (state_q == ACCESS && !is_load && !err_q),
        .be   (be_q),
        .addr (idx_q),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

    // RAM output is live only in RESP; afterwards the captured copy is presented.
    always_comb begin
        mem_read_data = rd_hold_q;
        if (in_resp && is_load) begin
            mem_read_data = err_q ? 32'd0 : (ram_rdata >> {addr_q[1:0], 3'b000});
        end
    end

    assign mem_read_data_valid = in_resp && is_load && !reset;
    assign mem_write_ready     = in_resp && !is_load && !reset;
    assign busy                = (state_q != IDLE);
    assign access_err          = access_err_q;
    assign err_addr            = err_addr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: two responders (0 and 3 wait states) behind shared stimulus.
module tb_data_mem_responder;
    import dmem_pkg::*;

    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        reset, en, err_clear, sel;
    logic [1:0]  size;
    logic [31:0] addr, wdata;

    logic [31:0] rd0, rd3, eaddr0, eaddr3;
    logic        vld0, vld3, rdy0, rdy3, busy0, busy3, aerr0, aerr3;

    data_mem_responder #(.WAIT_STATES(0)) dut0 (
        .CLK(CLK), .reset(reset), .memory_en(en & ~sel), .store_size(size),
        .mem_addr(addr), .mem_write_data(wdata), .mem_read_data(rd0),
        .mem_read_data_valid(vld0), .mem_write_ready(rdy0), .busy(busy0),
        .access_err(aerr0), .err_addr(eaddr0), .err_clear(err_clear & ~sel)
    );

    data_mem_responder #(.WAIT_STATES(3)) dut3 (
        .CLK(CLK), .reset(reset), .memory_en(en & sel), .store_size(size),
        .mem_addr(addr), .mem_write_data(wdata), .mem_read_data(rd3),
        .mem_read_data_valid(vld3), .mem_write_ready(rdy3), .busy(busy3),
        .access_err(aerr3), .err_addr(eaddr3), .err_clear(err_clear & sel)
    );

    logic [31:0] rd, eaddr;
    logic        vld, rdy, busy, aerr;
    assign rd    = sel ? rd3    : rd0;
    assign vld   = sel ? vld3   : vld0;
    assign rdy   = sel ? rdy3   : rdy0;
    assign busy  = sel ? busy3  : busy0;
    assign aerr  = sel ? aerr3  : aerr0;
    assign eaddr = sel ? eaddr3 : eaddr0;

    typedef struct packed {
        logic        is_load;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   pulses = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (vld || rdy) begin
            pulses++;
            if (sb.size() == 0) begin
                check("spurious_pulse", {30'd0, vld, rdy}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", {30'd0, vld, rdy}, e.is_load ? 32'd2 : 32'd1);
                if (e.is_load) check("read_data", rd, e.data);
            end
        end
    end

    // One full handshake; lat is the edge count from request to response pulse.
    task automatic req(input logic s, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_d, input int lat);
        exp_t e;
        int   k;
        logic got;
        logic b1;
        sel   = s;
        size  = sz;
        addr  = a;
        wdata = wd;
        e.is_load = (sz == SIZE_LD);
        e.data    = exp_d;
        sb.push_back(e);
        @(posedge CLK);
        #1 en = 1'b1;
        k   = 0;
        got = 1'b0;
        b1  = 1'b0;
        while (!got && k < 40) begin
            @(posedge CLK);
            k++;
            @(negedge CLK);
            if (k == 1) b1 = busy;
            if (vld || rdy) got = 1'b1;
        end
        check("latency", k, lat);
        check("busy_after_req", {31'd0, b1}, 32'd1);
        @(negedge CLK);
        check("busy_gap", {31'd0, busy}, 32'd1);
        en = 1'b0;
        @(negedge CLK);
        check("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    int p0;

    initial begin
        reset = 1'b1; en = 1'b0; err_clear = 1'b0; sel = 1'b0;
        size = SIZE_LD; addr = 32'd0; wdata = 32'd0;
        repeat (3) @(posedge CLK);
        #1 reset = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            sel = i[0];
            #1;
            check("rst_rd",    rd,    32'd0);
            check("rst_pulse", {30'd0, vld, rdy}, 32'd0);
            check("rst_busy",  {31'd0, busy}, 32'd0);
            check("rst_err",   {31'd0, aerr}, 32'd0);
            check("rst_eaddr", eaddr, 32'd0);
        end

        // Word store and load-back, zero wait states.
        req(0, SIZE_W,  32'h1004, 32'hDEADBEEF, 32'h0, 2);
        req(0, SIZE_LD, 32'h1004, 32'h0, 32'hDEADBEEF, 2);

        // Byte and half-word lanes.
        req(0, SIZE_W,  32'h1004, 32'h11223344, 32'h0, 2);
        req(0, SIZE_B,  32'h1005, 32'hFFFFFFAA, 32'h0, 2);
        req(0, SIZE_LD, 32'h1004, 32'h0, 32'h1122AA44, 2);
        req(0, SIZE_LD, 32'h1005, 32'h0, 32'h001122AA, 2);
        req(0, SIZE_H,  32'h1006, 32'h0000BEEF, 32'h0, 2);
        req(0, SIZE_LD, 32'h1006, 32'h0, 32'h0000BEEF, 2);
        req(0, SIZE_LD, 32'h1004, 32'h0, 32'hBEEFAA44, 2);
        req(0, SIZE_B,  32'h1007, 32'h0000005A, 32'h0, 2);
        req(0, SIZE_LD, 32'h1007, 32'h0, 32'h0000005A, 2);
        req(0, SIZE_LD, 32'h1004, 32'h0, 32'h5AEFAA44, 2);

        // Three wait states: exactly one pulse per request.
        p0 = pulses;
        req(1, SIZE_W,  32'h1008, 32'h13579BDF, 32'h0, 5);
        repeat (6) @(negedge CLK);
        check("one_pulse", pulses - p0, 32'd1);
        req(1, SIZE_LD, 32'h1008, 32'h0, 32'h13579BDF, 5);

        // Errors: misaligned store, below-base and beyond-top loads.
        req(0, SIZE_W,  32'h1000, 32'h0BADF00D, 32'h0, 2);
        check("rd_hold_over_store", rd, 32'h5AEFAA44);
        req(0, SIZE_W,  32'h1002, 32'h55555555, 32'h0, 1);
        check("err_set",  {31'd0, aerr}, 32'd1);
        check("err_addr", eaddr, 32'h1002);
        req(0, SIZE_LD, 32'h1000, 32'h0, 32'h0BADF00D, 2);
        req(0, SIZE_LD, 32'h0FFC, 32'h0, 32'h0, 1);
        check("err_addr_low", eaddr, 32'h0FFC);
        req(0, SIZE_LD, 32'h2000, 32'h0, 32'h0, 1);
        check("err_addr_high", eaddr, 32'h2000);
        req(0, SIZE_H,  32'h1001, 32'h0, 32'h0, 1);
        check("err_addr_sh", eaddr, 32'h1001);
        req(0, SIZE_W,  32'h1FFC, 32'hCAFEF00D, 32'h0, 2);
        req(0, SIZE_LD, 32'h1FFE, 32'h0, 32'h0000CAFE, 2);
        check("err_still_set", {31'd0, aerr}, 32'd1);
        @(posedge CLK);
        #1 err_clear = 1'b1;
        @(posedge CLK);
        #1 err_clear = 1'b0;
        @(negedge CLK);
        check("err_cleared", {31'd0, aerr}, 32'd0);

        // Reset while waiting drops the store.
        sel = 1'b1; size = SIZE_W; addr = 32'h1008; wdata = 32'hFFFFFFFF;
        p0 = pulses;
        @(posedge CLK);
        #1 en = 1'b1;
        repeat (2) @(posedge CLK);
        #1 reset = 1'b1;
        en = 1'b0;
        @(posedge CLK);
        #1 reset = 1'b0;
        @(negedge CLK);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        repeat (8) @(negedge CLK);
        check("rst_mid_no_pulse", pulses - p0, 32'd0);
        req(1, SIZE_LD, 32'h1008, 32'h0, 32'h13579BDF, 5);

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
